// File: rtl/pingpong_buffer_if.sv
// Producer/consumer/controller-facing signal bundle of the ping-pong buffer.
// The master side drives strobes, toggles and write data; the slave side is the buffer.
interface pingpong_buffer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CSIZE = $clog2(DEPTH + 1)
);
  logic             wr_toggle;
  logic             rd_toggle;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             rd_avail;
  logic [CSIZE-1:0] rd_count;
  logic             wr_room;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output wr_toggle, rd_toggle, wr_en, data_in, rd_en,
    input  data_out, rd_valid, rd_avail, rd_count, wr_room, err_ovf, err_unf
  );

  modport slave (
    input  wr_toggle, rd_toggle, wr_en, data_in, rd_en,
    output data_out, rd_valid, rd_avail, rd_count, wr_room, err_ovf, err_unf
  );
endinterface

// File: rtl/pingpong_buffer.sv
// Two-bank ping-pong buffer on one dataflow edge: producer fills one bank while the
// consumer drains the other; controller toggles commit and release whole frames.
module pingpong_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned ASIZE = $clog2(DEPTH),
  parameter int unsigned CSIZE = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  pingpong_buffer_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StFill, StFull} bank_state_e;

  localparam logic [CSIZE-1:0] DepthCnt = CSIZE'(DEPTH);
  localparam logic [CSIZE-1:0] OneCnt   = CSIZE'(1);

  logic [WIDTH-1:0] mem_q [2][DEPTH];

  bank_state_e      state_q [2];
  bank_state_e      state_d [2];
  logic [CSIZE-1:0] count_q [2];
  logic [CSIZE-1:0] count_d [2];
  logic             bank_wr_q, bank_wr_d;
  logic             bank_rd_q, bank_rd_d;
  logic [CSIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [CSIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic             rd_ok;
  logic             wr_ok;

  // Events are applied in order read, release, write, commit so that each later
  // event sees the effect of the earlier ones within the same cycle.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bank_wr_d  = bank_wr_q;
    bank_rd_d  = bank_rd_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    err_ovf_d  = err_ovf_q;
    err_unf_d  = err_unf_q;

    rd_ok = bus.rd_en && (state_q[bank_rd_q] == StFull) && (rd_ptr_q < count_q[bank_rd_q]);
    if (rd_ok) begin
      data_out_d = mem_q[bank_rd_q][rd_ptr_q[ASIZE-1:0]];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + OneCnt;
    end else if (bus.rd_en) begin
      err_unf_d = 1'b1;
    end

    if (bus.rd_toggle) begin
      if (state_q[bank_rd_q] == StFull) begin
        state_d[bank_rd_q] = StEmpty;
        bank_rd_d          = ~bank_rd_q;
        rd_ptr_d           = '0;
      end else begin
        err_unf_d = 1'b1;
      end
    end

    wr_ok = bus.wr_en && (wr_ptr_q < DepthCnt);
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + OneCnt;
      if (state_d[bank_wr_q] == StEmpty) state_d[bank_wr_q] = StFill;
    end else if (bus.wr_en) begin
      err_ovf_d = 1'b1;
    end

    if (bus.wr_toggle) begin
      if (state_d[~bank_wr_q] == StEmpty) begin
        state_d[bank_wr_q] = StFull;
        count_d[bank_wr_q] = wr_ptr_d;
        bank_wr_d          = ~bank_wr_q;
        wr_ptr_d           = '0;
      end else begin
        err_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= StEmpty;
      state_q[1] <= StEmpty;
      count_q[0] <= '0;
      count_q[1] <= '0;
      bank_wr_q  <= 1'b0;
      bank_rd_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      bank_wr_q  <= bank_wr_d;
      bank_rd_q  <= bank_rd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

  // Storage is deliberately left unreset; stale words are never readable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[bank_wr_q][wr_ptr_q[ASIZE-1:0]] <= bus.data_in;
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_avail = (state_q[bank_rd_q] == StFull);
  assign bus.rd_count = bus.rd_avail ? count_q[bank_rd_q] : '0;
  assign bus.wr_room  = (wr_ptr_q < DepthCnt);
  assign bus.err_ovf  = err_ovf_q;
  assign bus.err_unf  = err_unf_q;

endmodule

// File: tb/tb_pingpong_buffer.sv
// Directed bench for pingpong_buffer: hand-computed expectations for frame commit,
// streaming, overflow, underflow, same-cycle toggles and asynchronous reset.
module tb_pingpong_buffer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 32;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  pingpong_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pingpong_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_toggle = 1'b0;
    bus.rd_toggle = 1'b0;
    bus.wr_en     = 1'b0;
    bus.rd_en     = 1'b0;
    bus.data_in   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    bus.wr_en   = 1'b1;
    bus.data_in = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic commit();
    bus.wr_toggle = 1'b1;
    tick();
    bus.wr_toggle = 1'b0;
  endtask

  task automatic release_frame();
    bus.rd_toggle = 1'b1;
    tick();
    bus.rd_toggle = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
    check_eq({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
    check_eq({tag, "_rd_avail"}, 32'(bus.rd_avail), 32'h0);
    check_eq({tag, "_rd_count"}, 32'(bus.rd_count), 32'h0);
    check_eq({tag, "_wr_room"},  32'(bus.wr_room),  32'h1);
    check_eq({tag, "_err_ovf"},  32'(bus.err_ovf),  32'h0);
    check_eq({tag, "_err_unf"},  32'(bus.err_unf),  32'h0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    idle_inputs();
    #2;

    // 1: single frame of four words
    do_reset();
    check_reset_outputs("t1_reset");
    for (int i = 0; i < 4; i++) write_word(WIDTH'(16'hA0 + i));
    check_eq("t1_avail_before_commit", 32'(bus.rd_avail), 32'h0);
    commit();
    check_eq("t1_rd_avail", 32'(bus.rd_avail), 32'h1);
    check_eq("t1_rd_count", 32'(bus.rd_count), 32'd4);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("t1_data%0d", i), 32'(bus.data_out), 32'hA0 + i);
      check_eq($sformatf("t1_valid%0d", i), 32'(bus.rd_valid), 32'h1);
    end
    bus.rd_en = 1'b0;
    release_frame();
    check_eq("t1_avail_after_release", 32'(bus.rd_avail), 32'h0);
    check_eq("t1_valid_idle", 32'(bus.rd_valid), 32'h0);
    check_eq("t1_err_unf", 32'(bus.err_unf), 32'h0);

    // 2: frame B written while frame A drains, then release A and commit B together
    do_reset();
    for (int i = 0; i < 8; i++) write_word(WIDTH'(16'hB0 + i));
    commit();
    check_eq("t2_countA", 32'(bus.rd_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.data_in = WIDTH'(16'hC0 + i);
      bus.rd_en   = 1'b1;
      tick();
      check_eq($sformatf("t2_A%0d", i), 32'(bus.data_out), 32'hB0 + i);
    end
    idle_inputs();
    bus.rd_toggle = 1'b1;
    bus.wr_toggle = 1'b1;
    tick();
    idle_inputs();
    check_eq("t2_availB", 32'(bus.rd_avail), 32'h1);
    check_eq("t2_countB", 32'(bus.rd_count), 32'd8);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("t2_B%0d", i), 32'(bus.data_out), 32'hC0 + i);
    end
    bus.rd_en = 1'b0;
    check_eq("t2_err_ovf", 32'(bus.err_ovf), 32'h0);
    check_eq("t2_err_unf", 32'(bus.err_unf), 32'h0);

    // 3: three commits with no release
    do_reset();
    for (int i = 0; i < 3; i++) write_word(WIDTH'(16'h10 + i));
    commit();
    for (int i = 0; i < 2; i++) write_word(WIDTH'(16'h20 + i));
    commit();
    write_word(WIDTH'(16'h30));
    commit();
    check_eq("t3_err_ovf", 32'(bus.err_ovf), 32'h1);
    check_eq("t3_rd_count", 32'(bus.rd_count), 32'd3);
    check_eq("t3_rd_avail", 32'(bus.rd_avail), 32'h1);
    check_eq("t3_err_unf", 32'(bus.err_unf), 32'h0);

    // 4: DEPTH+1 writes before commit
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      write_word(WIDTH'(16'h100 + i));
      if (i == DEPTH - 2) check_eq("t4_room_before_full", 32'(bus.wr_room), 32'h1);
    end
    check_eq("t4_room_full", 32'(bus.wr_room), 32'h0);
    check_eq("t4_ovf_not_yet", 32'(bus.err_ovf), 32'h0);
    write_word(WIDTH'(16'hDEAD));
    check_eq("t4_err_ovf", 32'(bus.err_ovf), 32'h1);
    commit();
    check_eq("t4_rd_count", 32'(bus.rd_count), DEPTH);
    check_eq("t4_room_after_commit", 32'(bus.wr_room), 32'h1);
    bus.rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check_eq($sformatf("t4_data%0d", i), 32'(bus.data_out), 32'h100 + i);
    end
    bus.rd_en = 1'b0;
    check_eq("t4_err_unf", 32'(bus.err_unf), 32'h0);

    // 5: underflow on empty buffer, pointers must not move
    do_reset();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("t5_rd_valid", 32'(bus.rd_valid), 32'h0);
    check_eq("t5_err_unf", 32'(bus.err_unf), 32'h1);
    check_eq("t5_data_hold", 32'(bus.data_out), 32'h0);
    release_frame();
    check_eq("t5_avail_after_bad_release", 32'(bus.rd_avail), 32'h0);
    write_word(WIDTH'(16'h55));
    write_word(WIDTH'(16'h66));
    commit();
    check_eq("t5_rd_count", 32'(bus.rd_count), 32'd2);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("t5_first_word", 32'(bus.data_out), 32'h55);
    check_eq("t5_err_ovf", 32'(bus.err_ovf), 32'h0);

    // 6: same-cycle release and commit with both banks in use, then async reset
    do_reset();
    write_word(WIDTH'(16'h11));
    write_word(WIDTH'(16'h22));
    commit();
    for (int i = 0; i < 3; i++) write_word(WIDTH'(16'h31 + i));
    bus.rd_toggle = 1'b1;
    bus.wr_toggle = 1'b1;
    tick();
    idle_inputs();
    check_eq("t6_err_ovf", 32'(bus.err_ovf), 32'h0);
    check_eq("t6_rd_avail", 32'(bus.rd_avail), 32'h1);
    check_eq("t6_rd_count", 32'(bus.rd_count), 32'd3);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq("t6_first_word", 32'(bus.data_out), 32'h31);
    bus.wr_en   = 1'b1;
    bus.data_in = WIDTH'(16'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async_reset");
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("t6_after_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
